fpnew_opgroup_out_arb: RTL and testbench

- Downstream of the per-format slices inside an opgroup block. Collects results from NumSlices format slices and arbitrates among them round-robin.
- Each slice supplies result, status, extension bit and tag.
- The winner is registered into a single output stage that feeds the FPU output multiplexer.
- Provides per-slice ready backpressure and an aggregated busy indication.

---
 rtl/fpnew_pkg.sv | 17 +
 rtl/fpnew_rr_pick.sv | 26 ++
 rtl/fpnew_opgroup_out_arb.sv | 104 ++++++++++
 tb/tb_fpnew_opgroup_out_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPU types: exception flag record and round-robin pointer helper.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    // The compare form equals (ptr+1) mod n because ptr is always below n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fpnew_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module fpnew_rr_pick #(
    parameter int unsigned  NumIn    = 4,
    localparam int unsigned PtrWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [PtrWidth-1:0] ptr_i,
    output logic [PtrWidth-1:0] gnt_idx_o,
    output logic                gnt_valid_o
);

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        for (int k = int'(NumIn) - 1; k >= 0; k--) begin
            for (int j = 0; j < int'(NumIn); j++) begin
                if (req_i[j] && (j == ((int'(ptr_i) + k) % int'(NumIn)))) begin
                    gnt_idx_o   = PtrWidth'(j);
                    gnt_valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpnew_opgroup_out_arb.sv
// Round-robin arbiter collecting per-format slice results into one output register.
module fpnew_opgroup_out_arb
    import fpnew_pkg::*;
#(
    parameter int unsigned  NumSlices = 4,
    parameter int unsigned  Width     = 64,
    parameter type          TagType   = logic,
    localparam int unsigned PtrWidth  = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumSlices-1:0][Width-1:0]   slice_result_i,
    input  status_t [NumSlices-1:0]           slice_status_i,
    input  logic [NumSlices-1:0]              slice_ext_bit_i,
    input  TagType [NumSlices-1:0]            slice_tag_i,
    input  logic [NumSlices-1:0]              slice_valid_i,
    output logic [NumSlices-1:0]              slice_ready_o,
    input  logic [NumSlices-1:0]              slice_busy_i,
    input  logic                              flush_i,
    output logic [Width-1:0]                  result_o,
    output status_t                           status_o,
    output logic                              extension_bit_o,
    output TagType                            tag_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);

    logic [PtrWidth-1:0] ptr_q, ptr_d, gnt_idx;
    logic                gnt_valid, load_en, accept;
    logic                out_valid_q, out_valid_d;
    logic [Width-1:0]    result_q, result_d;
    status_t             status_q, status_d;
    logic                ext_q, ext_d;
    TagType              tag_q, tag_d;

    fpnew_rr_pick #(
        .NumIn(NumSlices)
    ) i_rr_pick (
        .req_i      (slice_valid_i),
        .ptr_i      (ptr_q),
        .gnt_idx_o  (gnt_idx),
        .gnt_valid_o(gnt_valid)
    );

    assign load_en = (~out_valid_q | out_ready_i) & ~flush_i;
    assign accept  = load_en & gnt_valid;

    always_comb begin
        slice_ready_o = '0;
        result_d      = result_q;
        status_d      = status_q;
        ext_d         = ext_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        ptr_d         = ptr_q;
        for (int i = 0; i < int'(NumSlices); i++) begin
            if (gnt_idx == PtrWidth'(i)) begin
                // Ready is held low during reset even though load_en is high then.
                slice_ready_o[i] = accept & rst_ni;
                if (accept) begin
                    result_d = slice_result_i[i];
                    status_d = slice_status_i[i];
                    ext_d    = slice_ext_bit_i[i];
                    tag_d    = slice_tag_i[i];
                end
            end
        end
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ptr_d       = PtrWidth'(rr_next(32'(gnt_idx), NumSlices));
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            ext_q       <= 1'b0;
            tag_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            status_q    <= status_d;
            ext_q       <= ext_d;
            tag_q       <= tag_d;
        end
    end

    assign result_o        = result_q;
    assign status_o        = status_q;
    assign extension_bit_o = ext_q;
    assign tag_o           = tag_q;
    assign out_valid_o     = out_valid_q;
    assign busy_o          = out_valid_q | (|slice_busy_i);

endmodule

// File: tb/tb_fpnew_opgroup_out_arb.sv
// Scoreboard bench: a 4-slice and a 3-slice arbiter driven in lockstep against a queue model.
module tb_fpnew_opgroup_out_arb;
    import fpnew_pkg::*;

    typedef logic [3:0] tag_t;
    typedef struct packed {
        logic [63:0] res;
        status_t     st;
        logic        ext;
        tag_t        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][63:0] res_in;
    status_t [3:0]    st_in;
    logic [3:0]       ext_in;
    tag_t [3:0]       tag_in;
    logic [3:0]       valid = '0;
    logic [3:0]       busy = '0;
    logic             flush = 1'b0;
    logic             oready = 1'b0;

    logic [3:0]  rdy4;
    logic [2:0]  rdy3;
    logic [63:0] res_o [2];
    status_t     st_o  [2];
    logic        ext_o [2];
    tag_t        tag_o [2];
    logic        ov_o  [2];
    logic        bsy_o [2];

    fpnew_opgroup_out_arb #(.NumSlices(4), .Width(64), .TagType(tag_t)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .slice_result_i(res_in), .slice_status_i(st_in), .slice_ext_bit_i(ext_in),
        .slice_tag_i(tag_in), .slice_valid_i(valid), .slice_ready_o(rdy4),
        .slice_busy_i(busy), .flush_i(flush),
        .result_o(res_o[0]), .status_o(st_o[0]), .extension_bit_o(ext_o[0]), .tag_o(tag_o[0]),
        .out_valid_o(ov_o[0]), .out_ready_i(oready), .busy_o(bsy_o[0])
    );

    fpnew_opgroup_out_arb #(.NumSlices(3), .Width(64), .TagType(tag_t)) dut3 (
        .clk_i(clk), .rst_ni(rst_n),
        .slice_result_i(res_in[2:0]), .slice_status_i(st_in[2:0]), .slice_ext_bit_i(ext_in[2:0]),
        .slice_tag_i(tag_in[2:0]), .slice_valid_i(valid[2:0]), .slice_ready_o(rdy3),
        .slice_busy_i(busy[2:0]), .flush_i(flush),
        .result_o(res_o[1]), .status_o(st_o[1]), .extension_bit_o(ext_o[1]), .tag_o(tag_o[1]),
        .out_valid_o(ov_o[1]), .out_ready_i(oready), .busy_o(bsy_o[1])
    );

    int total = 0;
    int bad = 0;

    int   mp  [2];
    bit   mov [2];
    exp_t sb  [2][$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (p + k) % n;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic rnd();
        for (int s = 0; s < 4; s++) begin
            res_in[s] = {$urandom, $urandom};
            st_in[s]  = status_t'(5'($urandom));
            ext_in[s] = 1'($urandom);
            tag_in[s] = 4'($urandom);
        end
    endtask

    // Called at posedge+1; checks combinational outputs, advances the model, waits one cycle.
    task automatic step(input logic [3:0] v, input logic r, input logic f, input logic [3:0] b);
        int n, g;
        logic [3:0] vv, bb, er, gr;
        bit load;
        exp_t e;
        valid = v; oready = r; flush = f; busy = b;
        #1;
        for (int d = 0; d < 2; d++) begin
            n  = (d == 0) ? 4 : 3;
            vv = (d == 0) ? v : {1'b0, v[2:0]};
            bb = (d == 0) ? b : {1'b0, b[2:0]};
            gr = (d == 0) ? rdy4 : {1'b0, rdy3};
            load = (!mov[d] || r) && !f;
            g = pick(vv, mp[d], n);
            er = '0;
            if (load && g >= 0) er[g[1:0]] = 1'b1;
            chk($sformatf("ready_n%0d", n), 64'(gr), 64'(er));
            chk($sformatf("out_valid_n%0d", n), 64'(ov_o[d]), 64'(mov[d]));
            chk($sformatf("busy_n%0d", n), 64'(bsy_o[d]), 64'(mov[d] | (|bb)));
            if (f) begin
                if (mov[d] && !r) void'(sb[d].pop_front());
                mov[d] = 1'b0;
            end else if (load && g >= 0) begin
                e.res = res_in[g[1:0]];
                e.st  = st_in[g[1:0]];
                e.ext = ext_in[g[1:0]];
                e.tag = tag_in[g[1:0]];
                sb[d].push_back(e);
                mp[d]  = (g + 1) % n;
                mov[d] = 1'b1;
            end else if (r) begin
                mov[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rstep(input logic [3:0] v, input logic r, input logic f, input logic [3:0] b);
        rnd();
        step(v, r, f, b);
    endtask

    // Monitor: pops on each output handshake and checks stall stability.
    initial begin : monitor
        exp_t e;
        logic [63:0] pr [2];
        tag_t pt [2];
        bit pstall [2];
        pstall[0] = 1'b0;
        pstall[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    pstall[d] = 1'b0;
                end else begin
                    if (pstall[d]) begin
                        chk($sformatf("stall_valid_%0d", d), 64'(ov_o[d]), 64'(1));
                        chk($sformatf("stall_result_%0d", d), res_o[d], pr[d]);
                        chk($sformatf("stall_tag_%0d", d), 64'(tag_o[d]), 64'(pt[d]));
                    end
                    if (ov_o[d] && oready) begin
                        if (sb[d].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL sb_underflow_%0d got=output_valid exp=no_output", d);
                        end else begin
                            e = sb[d].pop_front();
                            chk($sformatf("result_%0d", d), res_o[d], e.res);
                            chk($sformatf("status_%0d", d), 64'(st_o[d]), 64'(e.st));
                            chk($sformatf("ext_%0d", d), 64'(ext_o[d]), 64'(e.ext));
                            chk($sformatf("tag_%0d", d), 64'(tag_o[d]), 64'(e.tag));
                        end
                    end
                    pstall[d] = ov_o[d] && !oready && !flush;
                    pr[d] = res_o[d];
                    pt[d] = tag_o[d];
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        mp[0] = 0; mp[1] = 0; mov[0] = 1'b0; mov[1] = 1'b0;
        rnd();
        valid = 4'b1111;
        #2;
        chk("reset_valid", 64'(ov_o[0]), 64'(0));
        chk("reset_result", res_o[0], 64'(0));
        chk("reset_tag", 64'(tag_o[0]), 64'(0));
        chk("reset_ready", 64'(rdy4), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (6) rstep(4'b1111, 1'b1, 1'b0, 4'b0000);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0000);

        rnd();
        res_in[2] = 64'h3FF0_0000_0000_0000;
        tag_in[2] = 4'd5;
        step(4'b0100, 1'b1, 1'b0, 4'b0000);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0000);

        rstep(4'b0001, 1'b1, 1'b0, 4'b0000);
        repeat (3) rstep(4'b1010, 1'b0, 1'b0, 4'b0000);
        rstep(4'b1010, 1'b1, 1'b0, 4'b0000);
        rstep(4'b1000, 1'b1, 1'b0, 4'b0000);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0000);

        rstep(4'b0001, 1'b1, 1'b0, 4'b0000);
        rstep(4'b0001, 1'b0, 1'b1, 4'b0000);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0000);
        rstep(4'b1111, 1'b1, 1'b0, 4'b0000);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0010);
        rstep(4'b0000, 1'b1, 1'b0, 4'b0100);

        for (int i = 0; i < 8; i++)
            rstep((i % 2) ? 4'b0100 : 4'b0001, 1'b1, 1'b0, 4'b0000);

        rstep(4'b1111, 1'b1, 1'b0, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(ov_o[0]), 64'(0));
        chk("midreset_result", res_o[0], 64'(0));
        chk("midreset_ready", 64'(rdy4), 64'(0));
        chk("midreset_valid3", 64'(ov_o[1]), 64'(0));
        for (int d = 0; d < 2; d++) begin
            sb[d].delete();
            mp[d] = 0;
            mov[d] = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rstep(4'b1010, 1'b1, 1'b0, 4'b0000);

        for (int i = 0; i < 300; i++)
            rstep(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  4'($urandom));

        repeat (3) rstep(4'b0000, 1'b1, 1'b0, 4'b0000);
        chk("sb_left_n4", 64'(sb[0].size()), 64'(0));
        chk("sb_left_n3", 64'(sb[1].size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
